// File: rtl/ps2_key_event_fifo_if.sv
// Key-event stream between the PS/2 receiver and its consumer (valid/ready, FWFT head).
interface ps2_key_event_fifo_if;
  logic       evtValid;
  logic       evtReady;
  logic [7:0] evtCode;
  logic       evtBreak;
  logic       evtExtended;
  logic [1:0] keyClass;
  logic [3:0] keyValue;

  modport master (
    output evtValid, evtCode, evtBreak, evtExtended, keyClass, keyValue,
    input  evtReady
  );

  modport slave (
    input  evtValid, evtCode, evtBreak, evtExtended, keyClass, keyValue,
    output evtReady
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard receiver: sync + falling-edge detect, frame check, F0/E0 folding,
// key translation and a first-word-fall-through event FIFO, all on clock50.
module ps2_key_event_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                         clock50,
  input  logic                         reset,
  input  logic                         keyboardClock,
  input  logic                         keyboardData,
  ps2_key_event_fifo_if.master         evt,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCount,
  output logic                         frameError,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [1:0] cls;
    logic [3:0] val;
  } evt_t;

  logic [SYNC_STAGES-1:0] r_kclk_sync;
  logic [SYNC_STAGES-1:0] r_kdat_sync;
  logic                   r_kclk_prev;
  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par_err;
  logic [TW-1:0]          r_tmo_cnt;
  logic                   r_frame_err;
  logic                   r_pend_break;
  logic                   r_pend_ext;
  evt_t                   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_valid;
  evt_t                   r_head;
  logic                   r_overflow;

  logic                   w_kclk;
  logic                   w_bit;
  logic                   w_fall;
  logic                   w_byte_done;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wr_en;
  logic                   w_bypass;
  logic [AW-1:0]          w_rd_next;
  logic [CW-1:0]          w_cnt_next;
  logic [1:0]             w_cls;
  logic [3:0]             w_val;
  evt_t                   w_new;
  evt_t                   w_head_next;

  assign w_kclk      = r_kclk_sync[SYNC_STAGES-1];
  assign w_bit       = r_kdat_sync[SYNC_STAGES-1];
  assign w_fall      = r_kclk_prev & ~w_kclk;
  assign w_byte_done = w_fall && (r_state == S_STOP) && w_bit && !r_par_err;
  assign w_push      = w_byte_done && (r_shift != 8'hF0) && (r_shift != 8'hE0);
  assign w_pop       = r_valid && evt.evtReady;
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_bypass    = w_wr_en && (r_count == CW'(w_pop));
  assign w_rd_next   = r_rd_ptr + AW'(w_pop);
  assign w_cnt_next  = r_count + CW'(w_wr_en) - CW'(w_pop);
  assign w_new       = '{code: r_shift, brk: r_pend_break, ext: r_pend_ext, cls: w_cls, val: w_val};

  // Synchronise both PS/2 lines; idle-high reset avoids a false edge out of reset
  always_ff @(posedge clock50) begin
    if (reset) begin
      r_kclk_sync <= '1;
      r_kdat_sync <= '1;
      r_kclk_prev <= 1'b1;
    end else begin
      r_kclk_sync <= {r_kclk_sync[SYNC_STAGES-2:0], keyboardClock};
      r_kdat_sync <= {r_kdat_sync[SYNC_STAGES-2:0], keyboardData};
      r_kclk_prev <= w_kclk;
    end
  end

  // Frame receiver: start/data/parity/stop on falling edges, with inactivity timeout
  always_ff @(posedge clock50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_tmo_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_bit) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_par_err <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par_err <= (w_bit != ~^r_shift);
            r_state   <= S_STOP;
          end
          S_STOP: begin
            if (!w_bit || r_par_err) r_frame_err <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state     <= S_IDLE;
          r_tmo_cnt   <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  // Break/extended prefix folding; any frame error abandons a pending prefix
  always_ff @(posedge clock50) begin
    if (reset || r_frame_err) begin
      r_pend_break <= 1'b0;
      r_pend_ext   <= 1'b0;
    end else if (w_byte_done) begin
      if (r_shift == 8'hF0) begin
        r_pend_break <= 1'b1;
      end else if (r_shift == 8'hE0) begin
        r_pend_ext <= 1'b1;
      end else begin
        r_pend_break <= 1'b0;
        r_pend_ext   <= 1'b0;
      end
    end
  end

  // Make-code to class/value; only Enter survives the extended prefix
  always_comb begin
    w_cls = 2'd0;
    w_val = 4'd0;
    case (r_shift)
      8'h1C: begin w_cls = 2'd1; w_val = 4'd0; end
      8'h32: begin w_cls = 2'd1; w_val = 4'd1; end
      8'h21: begin w_cls = 2'd1; w_val = 4'd2; end
      8'h23: begin w_cls = 2'd1; w_val = 4'd3; end
      8'h24: begin w_cls = 2'd1; w_val = 4'd4; end
      8'h2B: begin w_cls = 2'd1; w_val = 4'd5; end
      8'h34: begin w_cls = 2'd1; w_val = 4'd6; end
      8'h33: begin w_cls = 2'd1; w_val = 4'd7; end
      8'h43: begin w_cls = 2'd1; w_val = 4'd8; end
      8'h3B: begin w_cls = 2'd1; w_val = 4'd9; end
      8'h45: begin w_cls = 2'd2; w_val = 4'd0; end
      8'h16: begin w_cls = 2'd2; w_val = 4'd1; end
      8'h1E: begin w_cls = 2'd2; w_val = 4'd2; end
      8'h26: begin w_cls = 2'd2; w_val = 4'd3; end
      8'h25: begin w_cls = 2'd2; w_val = 4'd4; end
      8'h2E: begin w_cls = 2'd2; w_val = 4'd5; end
      8'h36: begin w_cls = 2'd2; w_val = 4'd6; end
      8'h3D: begin w_cls = 2'd2; w_val = 4'd7; end
      8'h3E: begin w_cls = 2'd2; w_val = 4'd8; end
      8'h46: begin w_cls = 2'd2; w_val = 4'd9; end
      8'h5A: begin w_cls = 2'd3; w_val = 4'd0; end
      default: begin w_cls = 2'd0; w_val = 4'd0; end
    endcase
    if (r_pend_ext && (r_shift != 8'h5A)) begin
      w_cls = 2'd0;
      w_val = 4'd0;
    end
  end

  // Next head entry: freshly pushed event bypasses storage when it lands at the head
  always_comb begin
    w_head_next = '0;
    if (w_cnt_next != '0) begin
      w_head_next = w_bypass ? w_new : r_mem[w_rd_next];
    end
  end

  // Event storage
  always_ff @(posedge clock50) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_new;
  end

  // FIFO pointers, occupancy, registered head and overflow pulse
  always_ff @(posedge clock50) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_cnt_next;
      r_valid    <= (w_cnt_next != '0);
      r_head     <= w_head_next;
      r_overflow <= w_push && w_full && !w_pop;
    end
  end

  assign evt.evtValid    = r_valid;
  assign evt.evtCode     = r_head.code;
  assign evt.evtBreak    = r_head.brk;
  assign evt.evtExtended = r_head.ext;
  assign evt.keyClass    = r_head.cls;
  assign evt.keyValue    = r_head.val;
  assign fifoCount       = r_count;
  assign frameError      = r_frame_err;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Bench for ps2_key_event_fifo: queue-based event model plus directed frames.
module tb_ps2_key_event_fifo;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 50000;

  logic       clock50 = 1'b0;
  logic       reset;
  logic       kclk;
  logic       kdat;
  logic [3:0] fifoCount;
  logic       frameError;
  logic       overflow;

  ps2_key_event_fifo_if u_if ();

  ps2_key_event_fifo #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)
  ) u_dut (
    .clock50(clock50), .reset(reset), .keyboardClock(kclk), .keyboardData(kdat),
    .evt(u_if), .fifoCount(fifoCount), .frameError(frameError), .overflow(overflow)
  );

  always #5 clock50 = ~clock50;

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [1:0] cls;
    logic [3:0] val;
  } ev_t;

  int  checks   = 0;
  int  failures = 0;
  ev_t q[$];
  bit  m_brk = 0, m_ext = 0;
  int  exp_ferr = 0, exp_ovf = 0;
  int  ferr_seen = 0, ovf_seen = 0;

  logic [7:0] letters [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
  logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic void xlate(input logic [7:0] c, input logic ext,
                                output logic [1:0] cls, output logic [3:0] val);
    cls = 2'd0;
    val = 4'd0;
    if (c == 8'h5A) begin
      cls = 2'd3;
      return;
    end
    if (ext) return;
    for (int i = 0; i < 10; i++) begin
      if (letters[i] == c) begin cls = 2'd1; val = 4'(i); end
      if (digits[i] == c)  begin cls = 2'd2; val = 4'(i); end
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    ev_t e;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      e.code = b;
      e.brk  = m_brk;
      e.ext  = m_ext;
      xlate(b, m_ext, e.cls, e.val);
      if (q.size() < DEPTH) q.push_back(e);
      else exp_ovf++;
      m_brk = 0;
      m_ext = 0;
    end
  endfunction

  function automatic void model_err();
    exp_ferr++;
    m_brk = 0;
    m_ext = 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Per-cycle compare of the head against the model queue; pops follow the handshake
  always @(negedge clock50) begin
    if (!reset) begin
      if (frameError) ferr_seen++;
      if (overflow)   ovf_seen++;
      checks++;
      if (u_if.evtValid) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL head: evtValid with code %0h but model queue empty", u_if.evtCode);
        end else if (u_if.evtCode !== q[0].code || u_if.evtBreak !== q[0].brk ||
                     u_if.evtExtended !== q[0].ext || u_if.keyClass !== q[0].cls ||
                     u_if.keyValue !== q[0].val) begin
          failures++;
          $display("FAIL head: got code=%0h brk=%0b ext=%0b cls=%0d val=%0d expected code=%0h brk=%0b ext=%0b cls=%0d val=%0d",
                   u_if.evtCode, u_if.evtBreak, u_if.evtExtended, u_if.keyClass, u_if.keyValue,
                   q[0].code, q[0].brk, q[0].ext, q[0].cls, q[0].val);
        end
        if (u_if.evtReady && q.size() != 0) void'(q.pop_front());
      end else if ({u_if.evtCode, u_if.evtBreak, u_if.evtExtended, u_if.keyClass, u_if.keyValue} !== 16'h0) begin
        failures++;
        $display("FAIL empty_head: outputs %0h while empty, expected 0",
                 {u_if.evtCode, u_if.evtBreak, u_if.evtExtended, u_if.keyClass, u_if.keyValue});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  // One PS/2 frame; model updated just before the stop edge so it leads the DUT
  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      kdat = f[i];
      tick(4);
      if (i == 10) begin
        if (bad_par) model_err();
        else model_byte(b);
      end
      kclk = 1'b0;
      tick(4);
      kclk = 1'b1;
    end
    kdat = 1'b1;
    tick(4);
  endtask

  task automatic wait_valid(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock50);
      if (u_if.evtValid) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: evtValid still 0 after 20 cycles, expected 1", nm);
    end
  endtask

  task automatic drain(input int n);
    @(posedge clock50); #1;
    u_if.evtReady = 1'b1;
    tick(n);
    u_if.evtReady = 1'b0;
    @(negedge clock50);
  endtask

  task automatic chk_head(input string nm, input logic [7:0] code, input logic brk,
                          input logic ext, input logic [1:0] cls, input logic [3:0] val);
    chk({nm, "_code"}, 32'(u_if.evtCode), 32'(code));
    chk({nm, "_brk"},  32'(u_if.evtBreak), 32'(brk));
    chk({nm, "_ext"},  32'(u_if.evtExtended), 32'(ext));
    chk({nm, "_cls"},  32'(u_if.keyClass), 32'(cls));
    chk({nm, "_val"},  32'(u_if.keyValue), 32'(val));
  endtask

  initial begin
    int f0;
    reset = 1'b1;
    kclk  = 1'b1;
    kdat  = 1'b1;
    u_if.evtReady = 1'b0;
    tick(5);
    reset = 1'b0;
    @(negedge clock50);
    chk("rst_valid", 32'(u_if.evtValid), 0);
    chk("rst_count", 32'(fifoCount), 0);
    chk("rst_ferr",  32'(frameError), 0);
    chk("rst_ovf",   32'(overflow), 0);

    // Plain make code
    send_frame(8'h1C, 0);
    wait_valid("t1_valid");
    chk_head("t1", 8'h1C, 0, 0, 2'd1, 4'd0);
    chk("t1_count", 32'(fifoCount), 1);
    drain(1);
    chk("t1_drained", 32'(fifoCount), 0);

    // Break prefix folds into one event
    send_frame(8'hF0, 0);
    send_frame(8'h16, 0);
    wait_valid("t2_valid");
    chk_head("t2", 8'h16, 1, 0, 2'd2, 4'd1);
    chk("t2_count", 32'(fifoCount), 1);
    drain(1);

    // Extended: keypad Enter keeps its class, other extended codes do not
    send_frame(8'hE0, 0);
    send_frame(8'h5A, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    @(negedge clock50);
    chk("t3_count", 32'(fifoCount), 2);
    chk_head("t3a", 8'h5A, 0, 1, 2'd3, 4'd0);
    drain(1);
    chk_head("t3b", 8'h75, 0, 1, 2'd0, 4'd0);
    drain(1);

    // Bad parity: error pulse and no event, then a clean letter
    f0 = ferr_seen;
    send_frame(8'h1C, 1);
    tick(4);
    chk("t4_ferr", 32'(ferr_seen - f0), 1);
    chk("t4_count", 32'(fifoCount), 0);
    send_frame(8'h32, 0);
    wait_valid("t4_valid");
    chk_head("t4", 8'h32, 0, 0, 2'd1, 4'd1);
    drain(1);

    // Partial frame abandoned by the inactivity timeout
    f0 = ferr_seen;
    for (int i = 0; i < 5; i++) begin
      kdat = (i == 0) ? 1'b0 : 1'(i & 1);
      tick(4);
      kclk = 1'b0;
      tick(4);
      kclk = 1'b1;
    end
    kdat = 1'b1;
    tick(TIMEOUT + 20);
    model_err();
    chk("t5_ferr", 32'(ferr_seen - f0), 1);
    chk("t5_count", 32'(fifoCount), 0);
    send_frame(8'h45, 0);
    wait_valid("t5_valid");
    chk_head("t5", 8'h45, 0, 0, 2'd2, 4'd0);
    drain(1);

    // Overflow: nine codes into an eight-deep FIFO, then back-to-back drain
    for (int i = 0; i < 9; i++) send_frame(letters[i], 0);
    tick(4);
    @(negedge clock50);
    chk("t6_count", 32'(fifoCount), 8);
    chk("t6_ovf", 32'(ovf_seen), 1);
    chk_head("t6_first", 8'h1C, 0, 0, 2'd1, 4'd0);
    @(posedge clock50); #1;
    u_if.evtReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock50);
      chk("t6_drain_valid", 32'(u_if.evtValid), 1);
    end
    @(negedge clock50);
    chk("t6_drain_empty", 32'(u_if.evtValid), 0);
    u_if.evtReady = 1'b0;
    chk("t6_model_empty", 32'(q.size()), 0);

    chk("total_ferr", 32'(ferr_seen), 2);
    chk("model_ferr", 32'(ferr_seen), 32'(exp_ferr));
    chk("model_ovf", 32'(ovf_seen), 32'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
# ps2_key_event_fifo

PS/2 keyboard receiver that runs entirely in the `clock50` domain. It synchronises and edge-detects `keyboardClock`, deframes 11-bit PS/2 frames and checks the start, odd-parity and stop bits. It folds the `F0` (break) and `E0` (extended) prefixes into single key events, translates the A–J / 0–9 / Enter make codes into a class/value pair, and buffers the events in a parametrised first-word-fall-through FIFO behind a valid/ready handshake. It sits between the PS/2 pins and the game/input logic, replacing direct sampling of scancodes on the keyboard clock.

## Interface
- `FIFO_DEPTH`, 8: event entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000: `clock50` cycles without a keyboard clock falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `SYNC_STAGES`, 2: synchroniser flops on `keyboardClock` and `keyboardData`; ≥2.
- `clock50` in 1: the only clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `keyboardClock` in 1: PS/2 CLK, asynchronous, idles high.
- `keyboardData` in 1: PS/2 DAT, asynchronous, idles high.
- `evtValid` out 1: FIFO head holds an event.
- `evtReady` in 1: consumer accepts the head event.
- `evtCode` out 8: scancode of the head event, prefixes stripped.
- `evtBreak` out 1: head event is a key release.
- `evtExtended` out 1: head event was prefixed by `E0`.
- `keyClass` out 2: 0 unknown, 1 letter, 2 digit, 3 enter.
- `keyValue` out 4: letter or digit value, 0–9.
- `fifoCount` out clog2(FIFO_DEPTH)+1: number of stored entries.
- `frameError` out 1: one-cycle pulse on a start, parity, stop or timeout error.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Synchroniser:** both lines pass through `SYNC_STAGES` flops. Those flops reset to 1.
- **Edge detect:** a falling edge is sync clock 1→0 between consecutive cycles. The bit is sampled from sync data in the same cycle.
- **Receive FSM states:** IDLE, DATA, PARITY, STOP. It acts only on falling-edge cycles, except for the timeout.
  - IDLE: if the bit is 0, go to DATA with bit count 0. If the bit is 1, pulse `frameError` and stay in IDLE.
  - DATA: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: the parity bit must equal ~^data (odd parity over data plus parity). A mismatch is recorded; go to STOP.
  - STOP: the bit must be 1. With no recorded error, the byte is complete; otherwise pulse `frameError` and discard it. Return to IDLE either way.
- **Timeout:** the counter clears on every falling edge and counts in any state other than IDLE. On reaching `TIMEOUT_CYCLES`, go to IDLE, pulse `frameError`, and clear the pending flags.
- **Byte handling:**
  - `F0` sets `pendBreak`.
  - `E0` sets `pendExt`.
  - Any other byte pushes the event {code, `pendBreak`, `pendExt`} and clears both flags.
  - A frame error also clears both flags.
- **Translation:** computed at push time and stored in the FIFO.
  - Letters: `1C`,`32`,`21`,`23`,`24`,`2B`,`34`,`33`,`43`,`3B` → class 1, values 0–9 in that order.
  - Digits: `45`,`16`,`1E`,`26`,`25`,`2E`,`36`,`3D`,`3E`,`46` → class 2, values 0–9 in that order.
  - `5A` → class 3, value 0. This applies with or without `E0`, so keypad Enter maps the same.
  - Every other code → class 0, value 0.
  - For any extended code other than `5A`, class is 0.
- **FIFO:**
  - Pop when `evtValid && evtReady`.
  - Push when full with no pop in the same cycle: the new event is dropped and `overflow` pulses.
  - Push and pop in the same cycle while full: both occur and the count is unchanged.
  - Push and pop in the same cycle while empty cannot happen, because the head is not yet valid.
  - The `evt*`, `keyClass` and `keyValue` outputs show the head entry and are 0 when empty.
- **Reset:**
  - FSM goes to IDLE; counters, pending flags and FIFO pointers clear.
  - All outputs are 0.
  - Reset in the middle of a frame discards it; the remaining bits are then treated as IDLE noise, which may pulse `frameError`.

## Timing
- Pin-to-detect latency is `SYNC_STAGES`+1 cycles after the pin falls.
- Let D be the cycle in which the stop-bit falling edge is detected. The push is registered at the end of D; `evtValid` and the `evt*` outputs are valid at D+1 if the FIFO was empty, and `fifoCount` updates at D+1.
- `frameError` is high at D+1 for one cycle. `overflow` is high in the cycle after the dropped push, for one cycle.
- Pop: the head advances in the cycle after `evtValid && evtReady`. Back-to-back pops sustain one event per cycle.
- `evtReady` may stay high continuously. Outputs are stable while `evtValid && !evtReady`.

## Test plan
- Frame `1C` (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) → `evtValid` at D+1 with code `1C`, break 0, ext 0, class 1, value 0; `fifoCount` 1.
- Frames `F0`,`16` (parity 1, then parity 0) → exactly one event: code `16`, break 1, class 2, value 1.
- Frames `E0`,`5A` then `E0`,`75` → event 1: ext 1, class 3. Event 2: ext 1, class 0, value 0.
- Frame `1C` with parity bit 1 → `frameError` pulse and no event. A following `F0`-less `32` yields break 0, class 1, value 1.
- Stop after the 4th data bit with no further edges for 50000 cycles → `frameError`, FSM in IDLE; the next good `45` frame yields class 2, value 0.
- `evtReady`=0 while 9 make codes are sent with `FIFO_DEPTH`=8 → `fifoCount` 8 and one `overflow` pulse. Draining with `evtReady`=1 returns the first 8 codes in order over 8 consecutive cycles.
